// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch stage and the decoder.
package riscv_pkg;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    // RV32I major opcodes
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcMisc   = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFlush
    } fetch_state_e;

    // One queue slot: instruction word plus the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, instr} pairs with synchronous flush.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t           r_mem [DEPTH];
    logic [PtrW-1:0]        r_wr_ptr;
    logic [PtrW-1:0]        r_rd_ptr;
    logic [PtrW:0]          r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Flush overrides both push and pop in the same cycle
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            r_count <= r_count + (PtrW+1)'(w_do_push) - (PtrW+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: contents are only observed when non-empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PtrW+1)'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, credit-limited memory requests, response queue, redirect flush.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_e   r_state, w_state_next;
    logic [31:0]    r_pc, w_pc_next;
    // PC of the next response expected from memory; responses are in order
    // and a redirect kills everything older, so one counter tags every word.
    logic [31:0]    r_rsp_pc, w_rsp_pc_next;
    // Requests accepted but not yet answered; in FLUSH this is the kill count
    logic [CntW-1:0] r_out, w_out_next;

    logic           w_push, w_pop, w_flush;
    logic           w_req_valid, w_accept, w_credit_ok;
    logic [CntW:0]  w_in_use;
    logic [31:0]    w_target;
    fetch_entry_t   w_push_data, w_head;
    logic [CntW-1:0] w_fifo_count;
    logic           w_fifo_empty, w_fifo_full;

    assign w_target    = word_align(redirect_pc);
    assign w_in_use    = {1'b0, r_out} + {1'b0, w_fifo_count};
    assign w_credit_ok = (w_in_use < (CntW+1)'(DEPTH));
    assign w_req_valid = (r_state == StRun) & ~redirect_valid & w_credit_ok;
    assign w_accept    = w_req_valid & imem_req_ready;
    assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

    // State, PC and outstanding-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StBoot;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_rsp_pc <= w_rsp_pc_next;
            r_out    <= w_out_next;
        end
    end

    // Next-state and queue control; a redirect beats push, pop and request
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_rsp_pc_next = r_rsp_pc;
        w_out_next    = r_out;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        unique case (r_state)
            StBoot: begin
                w_state_next = StRun;
                if (redirect_valid) begin
                    w_pc_next     = w_target;
                    w_rsp_pc_next = w_target;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    w_flush       = 1'b1;
                    w_pc_next     = w_target;
                    w_rsp_pc_next = w_target;
                    w_out_next    = r_out - CntW'(imem_rsp_valid);
                    if (w_out_next != '0) w_state_next = StFlush;
                end else begin
                    if (w_accept) w_pc_next = r_pc + 32'd4;
                    if (imem_rsp_valid) begin
                        w_push        = 1'b1;
                        w_rsp_pc_next = r_rsp_pc + 32'd4;
                    end
                    w_pop      = ~w_fifo_empty & instr_ready;
                    w_out_next = r_out + CntW'(w_accept) - CntW'(imem_rsp_valid);
                end
            end
            StFlush: begin
                // Stale responses are dropped and only decrement the kill count
                if (imem_rsp_valid && r_out != '0) w_out_next = r_out - CntW'(1);
                if (redirect_valid) begin
                    w_flush       = 1'b1;
                    w_pc_next     = w_target;
                    w_rsp_pc_next = w_target;
                end
                if (w_out_next == '0) w_state_next = StRun;
            end
            default: w_state_next = StBoot;
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = ~w_fifo_empty;
    assign instr_out      = w_fifo_empty ? NopInstr : w_head.instr;
    assign instr_pc       = w_fifo_empty ? r_rsp_pc : w_head.pc;

endmodule
